// File: rtl/nut_trap_monitor.sv
// Multi-hart trap monitor: latches the first trap or watchdog timeout per hart and reports records round-robin on one valid/ready port.
// Latency: trap in cycle T gives rpt_valid in cycle T+2; one record per 2 cycles at most.
// Backpressure: a record is held stable until rpt_ready; pending harts wait in PEND.
module nut_trap_monitor #(
  parameter int  NR_HART  = 2,
  parameter int  XLEN     = 64,
  parameter int  CODE_W   = 32,
  parameter int  CNT_W    = 64,
  parameter int  COMMIT_W = 2,
  parameter int  TIMEOUT  = 5000,
  localparam int HID_W    = (NR_HART > 1) ? $clog2(NR_HART) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NR_HART-1:0]           hart_trap_valid,
  input  logic [NR_HART*CODE_W-1:0]    hart_trap_code,
  input  logic [NR_HART*XLEN-1:0]      hart_trap_pc,
  input  logic [NR_HART*COMMIT_W-1:0]  hart_commit,
  output logic                         rpt_valid,
  input  logic                         rpt_ready,
  output logic [HID_W-1:0]             rpt_hart,
  output logic [CODE_W-1:0]            rpt_code,
  output logic [XLEN-1:0]              rpt_pc,
  output logic [CNT_W-1:0]             rpt_cycles,
  output logic [CNT_W-1:0]             rpt_instrs,
  output logic                         all_done
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {H_RUN, H_PEND, H_DONE} hart_st_e;
  typedef enum logic {R_IDLE, R_SEND} rpt_st_e;

  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  hart_st_e          hst_q      [NR_HART];
  hart_st_e          hst_d      [NR_HART];
  logic [CNT_W-1:0]  instr_q    [NR_HART];
  logic [CNT_W-1:0]  instr_d    [NR_HART];
  logic [IDLE_W-1:0] idle_q     [NR_HART];
  logic [IDLE_W-1:0] idle_d     [NR_HART];
  logic [CODE_W-1:0] rec_code_q [NR_HART];
  logic [CODE_W-1:0] rec_code_d [NR_HART];
  logic [XLEN-1:0]   rec_pc_q   [NR_HART];
  logic [XLEN-1:0]   rec_pc_d   [NR_HART];
  logic [CNT_W-1:0]  rec_cyc_q  [NR_HART];
  logic [CNT_W-1:0]  rec_cyc_d  [NR_HART];
  logic [CNT_W-1:0]  rec_ins_q  [NR_HART];
  logic [CNT_W-1:0]  rec_ins_d  [NR_HART];

  rpt_st_e           rpt_st_q, rpt_st_d;
  logic [HID_W-1:0]  rr_q, rr_d;
  logic [HID_W-1:0]  rpt_hart_q, rpt_hart_d;
  logic [CODE_W-1:0] rpt_code_q, rpt_code_d;
  logic [XLEN-1:0]   rpt_pc_q, rpt_pc_d;
  logic [CNT_W-1:0]  rpt_cycles_q, rpt_cycles_d;
  logic [CNT_W-1:0]  rpt_instrs_q, rpt_instrs_d;
  logic              all_done_q, all_done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q  <= '0;
      for (int i = 0; i < NR_HART; i++) begin
        hst_q[i]      <= H_RUN;
        instr_q[i]    <= '0;
        idle_q[i]     <= '0;
        rec_code_q[i] <= '0;
        rec_pc_q[i]   <= '0;
        rec_cyc_q[i]  <= '0;
        rec_ins_q[i]  <= '0;
      end
      rpt_st_q     <= R_IDLE;
      rr_q         <= '0;
      rpt_hart_q   <= '0;
      rpt_code_q   <= '0;
      rpt_pc_q     <= '0;
      rpt_cycles_q <= '0;
      rpt_instrs_q <= '0;
      all_done_q   <= 1'b0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      hst_q        <= hst_d;
      instr_q      <= instr_d;
      idle_q       <= idle_d;
      rec_code_q   <= rec_code_d;
      rec_pc_q     <= rec_pc_d;
      rec_cyc_q    <= rec_cyc_d;
      rec_ins_q    <= rec_ins_d;
      rpt_st_q     <= rpt_st_d;
      rr_q         <= rr_d;
      rpt_hart_q   <= rpt_hart_d;
      rpt_code_q   <= rpt_code_d;
      rpt_pc_q     <= rpt_pc_d;
      rpt_cycles_q <= rpt_cycles_d;
      rpt_instrs_q <= rpt_instrs_d;
      all_done_q   <= all_done_d;
    end
  end

  always_comb begin : next_state
    logic [COMMIT_W-1:0] commit;
    logic [CNT_W:0]      sum;
    logic [CNT_W-1:0]    inc;
    logic                sel_vld;
    logic [HID_W-1:0]    sel_idx;
    int                  idx;
    commit       = '0;
    sum          = '0;
    inc          = '0;
    sel_vld      = 1'b0;
    sel_idx      = '0;
    idx          = 0;
    cycle_cnt_d  = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    hst_d        = hst_q;
    instr_d      = instr_q;
    idle_d       = idle_q;
    rec_code_d   = rec_code_q;
    rec_pc_d     = rec_pc_q;
    rec_cyc_d    = rec_cyc_q;
    rec_ins_d    = rec_ins_q;
    rpt_st_d     = rpt_st_q;
    rr_d         = rr_q;
    rpt_hart_d   = rpt_hart_q;
    rpt_code_d   = rpt_code_q;
    rpt_pc_d     = rpt_pc_q;
    rpt_cycles_d = rpt_cycles_q;
    rpt_instrs_d = rpt_instrs_q;

    for (int i = 0; i < NR_HART; i++) begin
      commit = hart_commit[i*COMMIT_W +: COMMIT_W];
      sum    = {1'b0, instr_q[i]} + (CNT_W+1)'(commit);
      inc    = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      if (hst_q[i] == H_RUN) begin
        instr_d[i] = inc;
        idle_d[i]  = (commit != '0) ? '0 : idle_q[i] + IDLE_W'(1);
        // A real trap takes priority over a watchdog expiring in the same cycle.
        if (hart_trap_valid[i]) begin
          hst_d[i]      = H_PEND;
          rec_code_d[i] = hart_trap_code[i*CODE_W +: CODE_W];
          rec_pc_d[i]   = hart_trap_pc[i*XLEN +: XLEN];
          rec_cyc_d[i]  = cycle_cnt_q;
          rec_ins_d[i]  = inc;
        end else if ((TIMEOUT > 0) && (commit == '0) && (idle_q[i] == IDLE_W'(TIMEOUT - 1))) begin
          hst_d[i]      = H_PEND;
          rec_code_d[i] = '1;
          rec_pc_d[i]   = '0;
          rec_cyc_d[i]  = cycle_cnt_q;
          rec_ins_d[i]  = inc;
        end
      end
    end

    // Round-robin search starts at rr and wraps once around the harts.
    for (int k = 0; k < NR_HART; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NR_HART) idx = idx - NR_HART;
      if (!sel_vld && hst_q[HID_W'(idx)] == H_PEND) begin
        sel_vld = 1'b1;
        sel_idx = HID_W'(idx);
      end
    end

    case (rpt_st_q)
      R_IDLE: begin
        if (sel_vld) begin
          rpt_st_d     = R_SEND;
          rpt_hart_d   = sel_idx;
          rpt_code_d   = rec_code_q[sel_idx];
          rpt_pc_d     = rec_pc_q[sel_idx];
          rpt_cycles_d = rec_cyc_q[sel_idx];
          rpt_instrs_d = rec_ins_q[sel_idx];
        end
      end
      R_SEND: begin
        if (rpt_ready) begin
          hst_d[rpt_hart_q] = H_DONE;
          rr_d     = (rpt_hart_q == HID_W'(NR_HART - 1)) ? '0 : rpt_hart_q + HID_W'(1);
          rpt_st_d = R_IDLE;
        end
      end
      default: rpt_st_d = R_IDLE;
    endcase

    all_done_d = 1'b1;
    for (int i = 0; i < NR_HART; i++) begin
      if (hst_d[i] != H_DONE) all_done_d = 1'b0;
    end
    all_done_d = all_done_d | all_done_q;
  end

  always_comb begin : outputs
    rpt_valid  = (rpt_st_q == R_SEND);
    rpt_hart   = rpt_hart_q;
    rpt_code   = rpt_code_q;
    rpt_pc     = rpt_pc_q;
    rpt_cycles = rpt_cycles_q;
    rpt_instrs = rpt_instrs_q;
    all_done   = all_done_q;
  end

endmodule

// File: tb/tb_nut_trap_monitor.sv
// Randomized and directed bench for nut_trap_monitor, checked every cycle against a behavioural model.
module tb_nut_trap_monitor;
  localparam int NR = 2, XL = 64, CW = 32, CNTW = 8, CMW = 2, TO = 16, HW = 1;
  localparam longint MAXC = (longint'(1) << CNTW) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     hart_trap_valid;
  logic [NR*CW-1:0]  hart_trap_code;
  logic [NR*XL-1:0]  hart_trap_pc;
  logic [NR*CMW-1:0] hart_commit;
  logic              rpt_valid, rpt_ready;
  logic [HW-1:0]     rpt_hart;
  logic [CW-1:0]     rpt_code;
  logic [XL-1:0]     rpt_pc;
  logic [CNTW-1:0]   rpt_cycles, rpt_instrs;
  logic              all_done;

  nut_trap_monitor #(.NR_HART(NR), .XLEN(XL), .CODE_W(CW), .CNT_W(CNTW), .COMMIT_W(CMW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .hart_trap_valid(hart_trap_valid), .hart_trap_code(hart_trap_code),
    .hart_trap_pc(hart_trap_pc), .hart_commit(hart_commit), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_hart(rpt_hart), .rpt_code(rpt_code), .rpt_pc(rpt_pc), .rpt_cycles(rpt_cycles),
    .rpt_instrs(rpt_instrs), .all_done(all_done));

  always #5 clk = ~clk;

  logic          drv_tv    [NR];
  logic [CW-1:0] drv_code  [NR];
  logic [XL-1:0] drv_pc    [NR];
  int            drv_commit[NR];
  logic          drv_ready;

  typedef enum {M_RUN, M_PEND, M_DONE} mst_e;
  mst_e          m_st   [NR];
  longint        m_instr[NR];
  int            m_idle [NR];
  logic [CW-1:0] m_code [NR];
  logic [XL-1:0] m_pc   [NR];
  longint        m_rcyc [NR];
  longint        m_rins [NR];
  logic          m_vld, m_done;
  int            m_hart, m_rr;
  logic [CW-1:0] e_code;
  logic [XL-1:0] e_pc;
  longint        e_cyc, e_ins;
  longint        cyc;
  int            tests = 0, fails = 0;

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare();
    logic ok;
    tests++;
    ok = (rpt_valid === m_vld) && (all_done === m_done);
    if (m_vld)
      ok = ok && (rpt_hart === HW'(m_hart)) && (rpt_code === e_code) && (rpt_pc === e_pc) &&
           (rpt_cycles === CNTW'(e_cyc)) && (rpt_instrs === CNTW'(e_ins));
    if (!ok) begin
      fails++;
      $display("FAIL model cyc=%0d: got v=%b d=%b h=%0d code=%h pc=%h cy=%0d in=%0d; expected v=%b d=%b h=%0d code=%h pc=%h cy=%0d in=%0d",
               cyc, rpt_valid, all_done, rpt_hart, rpt_code, rpt_pc, rpt_cycles, rpt_instrs,
               m_vld, m_done, m_hart, e_code, e_pc, e_cyc, e_ins);
    end
  endtask

  task automatic clear_drv();
    for (int i = 0; i < NR; i++) begin
      drv_tv[i] = 1'b0; drv_code[i] = '0; drv_pc[i] = '0; drv_commit[i] = 0;
    end
    drv_ready = 1'b1;
  endtask

  task automatic apply_drv();
    for (int i = 0; i < NR; i++) begin
      hart_trap_valid[i]          = drv_tv[i];
      hart_trap_code[i*CW +: CW]  = drv_code[i];
      hart_trap_pc[i*XL +: XL]    = drv_pc[i];
      hart_commit[i*CMW +: CMW]   = CMW'(drv_commit[i]);
    end
    rpt_ready = drv_ready;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_st[i] = M_RUN; m_instr[i] = 0; m_idle[i] = 0;
      m_code[i] = '0; m_pc[i] = '0; m_rcyc[i] = 0; m_rins[i] = 0;
    end
    m_vld = 1'b0; m_done = 1'b0; m_hart = 0; m_rr = 0;
    e_code = '0; e_pc = '0; e_cyc = 0; e_ins = 0;
    cyc = 0;
  endtask

  // Advance the model across one clock edge using the inputs driven for the current cycle.
  task automatic model_step();
    int pick, done_h, idx, c;
    longint inc, cy;
    logic all;
    pick = -1; done_h = -1;
    if (!m_vld) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_rr + k) % NR;
        if (pick < 0 && m_st[idx] == M_PEND) pick = idx;
      end
    end else if (drv_ready) begin
      done_h = m_hart;
    end
    cy = (cyc > MAXC) ? MAXC : cyc;
    for (int i = 0; i < NR; i++) begin
      if (m_st[i] == M_RUN) begin
        c = drv_commit[i];
        inc = m_instr[i] + c;
        if (inc > MAXC) inc = MAXC;
        if (drv_tv[i]) begin
          m_st[i] = M_PEND; m_code[i] = drv_code[i]; m_pc[i] = drv_pc[i]; m_rcyc[i] = cy; m_rins[i] = inc;
        end else if (TO > 0 && c == 0 && m_idle[i] == TO - 1) begin
          m_st[i] = M_PEND; m_code[i] = '1; m_pc[i] = '0; m_rcyc[i] = cy; m_rins[i] = inc;
        end
        m_instr[i] = inc;
        m_idle[i]  = (c != 0) ? 0 : m_idle[i] + 1;
      end
    end
    if (pick >= 0) begin
      m_vld = 1'b1; m_hart = pick;
      e_code = m_code[pick]; e_pc = m_pc[pick]; e_cyc = m_rcyc[pick]; e_ins = m_rins[pick];
    end
    if (done_h >= 0) begin
      m_st[done_h] = M_DONE; m_rr = (done_h + 1) % NR; m_vld = 1'b0;
    end
    all = 1'b1;
    for (int i = 0; i < NR; i++) if (m_st[i] != M_DONE) all = 1'b0;
    m_done = m_done | all;
    cyc++;
  endtask

  task automatic step();
    compare();
    apply_drv();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_drv(); apply_drv();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Asynchronous reset asserted between edges; outputs must drop before any clock edge.
  task automatic pulse_reset_check();
    #2 reset = 1'b0;
    #1;
    lit("rst_async_valid", 64'(rpt_valid), 64'h0);
    lit("rst_async_done", 64'(all_done), 64'h0);
    clear_drv(); apply_drv();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int mode[NR];
    int rdy_p;
    clear_drv(); apply_drv();
    do_reset();
    lit("reset_valid", 64'(rpt_valid), 64'h0);
    lit("reset_done", 64'(all_done), 64'h0);

    // Hart0 traps at cycle 10; hart1 never commits and times out at cycle 15.
    for (int c = 0; c < 20; c++) begin
      clear_drv();
      drv_commit[0] = 1;
      if (c == 10) begin drv_tv[0] = 1'b1; drv_code[0] = 32'h0; drv_pc[0] = 64'h8000_0100; end
      if (c == 11) lit("t1_latency_valid", 64'(rpt_valid), 64'h0);
      if (c == 12) begin
        lit("t1_valid", 64'(rpt_valid), 64'h1);
        lit("t1_hart", 64'(rpt_hart), 64'h0);
        lit("t1_pc", rpt_pc, 64'h8000_0100);
        lit("t1_cycles", 64'(rpt_cycles), 64'd10);
        lit("t1_instrs", 64'(rpt_instrs), 64'd11);
      end
      if (c == 13) lit("t1_bubble", 64'(rpt_valid), 64'h0);
      if (c == 17) begin
        lit("t4_valid", 64'(rpt_valid), 64'h1);
        lit("t4_hart", 64'(rpt_hart), 64'h1);
        lit("t4_code", 64'(rpt_code), 64'hFFFF_FFFF);
        lit("t4_pc", rpt_pc, 64'h0);
        lit("t4_cycles", 64'(rpt_cycles), 64'd15);
        lit("t4_instrs", 64'(rpt_instrs), 64'd0);
        lit("t4_done_early", 64'(all_done), 64'h0);
      end
      if (c == 18) lit("t4_all_done", 64'(all_done), 64'h1);
      step();
    end
    pulse_reset_check();

    // Both harts trap in cycle 5.
    for (int c = 0; c < 12; c++) begin
      clear_drv();
      drv_commit[0] = 1; drv_commit[1] = 1;
      if (c == 5) begin
        drv_tv[0] = 1'b1; drv_code[0] = 32'd0; drv_pc[0] = 64'h100;
        drv_tv[1] = 1'b1; drv_code[1] = 32'd1; drv_pc[1] = 64'h200;
      end
      if (c == 7) begin
        lit("t2_h0_valid", 64'(rpt_valid), 64'h1);
        lit("t2_h0_hart", 64'(rpt_hart), 64'h0);
        lit("t2_h0_instrs", 64'(rpt_instrs), 64'd6);
      end
      if (c == 8) lit("t2_bubble", 64'(rpt_valid), 64'h0);
      if (c == 9) begin
        lit("t2_h1_valid", 64'(rpt_valid), 64'h1);
        lit("t2_h1_code", 64'(rpt_code), 64'h1);
        lit("t2_h1_pc", rpt_pc, 64'h200);
        lit("t2_done_early", 64'(all_done), 64'h0);
      end
      if (c == 10) lit("t2_all_done", 64'(all_done), 64'h1);
      step();
    end

    // Backpressure: record held for 5 stalled cycles, accepted on the 6th.
    do_reset();
    for (int c = 0; c < 13; c++) begin
      clear_drv();
      drv_commit[0] = 2; drv_commit[1] = 1;
      drv_ready = (c == 9);
      if (c == 2) begin drv_tv[0] = 1'b1; drv_code[0] = 32'h55; drv_pc[0] = 64'h1234; end
      if (c == 3) begin drv_tv[1] = 1'b1; drv_code[1] = 32'h77; drv_pc[1] = 64'h5678; end
      if (c >= 4 && c <= 9) begin
        lit("t3_hold_valid", 64'(rpt_valid), 64'h1);
        lit("t3_hold_code", 64'(rpt_code), 64'h55);
        lit("t3_hold_pc", rpt_pc, 64'h1234);
        lit("t3_hold_cyc", 64'(rpt_cycles), 64'd2);
        lit("t3_hold_ins", 64'(rpt_instrs), 64'd6);
      end
      if (c == 10) lit("t3_bubble", 64'(rpt_valid), 64'h0);
      if (c == 11) begin
        lit("t3_h1_hart", 64'(rpt_hart), 64'h1);
        lit("t3_h1_cycles", 64'(rpt_cycles), 64'd3);
        lit("t3_h1_instrs", 64'(rpt_instrs), 64'd4);
      end
      step();
    end
    lit("t5_pre_valid", 64'(rpt_valid), 64'h1);
    pulse_reset_check();
    for (int c = 0; c < 8; c++) begin
      clear_drv();
      drv_commit[0] = 1; drv_commit[1] = 1;
      if (c == 4) begin drv_tv[0] = 1'b1; drv_code[0] = 32'h9; drv_pc[0] = 64'h40; end
      if (c == 6) begin
        lit("t5_post_valid", 64'(rpt_valid), 64'h1);
        lit("t5_post_code", 64'(rpt_code), 64'h9);
        lit("t5_post_cycles", 64'(rpt_cycles), 64'd4);
        lit("t5_post_instrs", 64'(rpt_instrs), 64'd5);
      end
      step();
    end

    // Counter saturation with 8-bit counters.
    do_reset();
    for (int c = 0; c < 304; c++) begin
      clear_drv();
      drv_commit[0] = 3; drv_commit[1] = 1;
      if (c == 300) begin drv_tv[0] = 1'b1; drv_code[0] = 32'h3; drv_pc[0] = 64'hABC; end
      if (c == 302) begin
        lit("t6_valid", 64'(rpt_valid), 64'h1);
        lit("t6_cycles", 64'(rpt_cycles), 64'd255);
        lit("t6_instrs", 64'(rpt_instrs), 64'd255);
      end
      step();
    end

    // Randomized episodes: mixed commit patterns, sparse traps, random backpressure.
    for (int ep = 0; ep < 16; ep++) begin
      do_reset();
      for (int i = 0; i < NR; i++) mode[i] = $urandom_range(0, 3);
      rdy_p = $urandom_range(20, 100);
      for (int c = 0; c < 150; c++) begin
        clear_drv();
        for (int i = 0; i < NR; i++) begin
          case (mode[i])
            0:       drv_commit[i] = 0;
            1:       drv_commit[i] = $urandom_range(0, 3);
            2:       drv_commit[i] = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 3);
            default: drv_commit[i] = (c % 20 == 0) ? 1 : 0;
          endcase
          if ($urandom_range(0, 59) == 0) begin
            drv_tv[i] = 1'b1; drv_code[i] = $urandom; drv_pc[i] = {$urandom, $urandom};
          end
        end
        drv_ready = ($urandom_range(0, 99) < rdy_p);
        if (c == 75 && (ep % 4) == 3) pulse_reset_check();
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
